// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU, B = load unit) and the
// register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int DR_W   = 3
);
  logic              A_REQ;
  logic [DR_W-1:0]   A_DR;
  logic [DATA_W-1:0] A_DATA;
  logic              A_GNT;
  logic              B_REQ;
  logic [DR_W-1:0]   B_DR;
  logic [DATA_W-1:0] B_DATA;
  logic              B_GNT;
  logic              LD_REG;
  logic [DR_W-1:0]   DRMUXOUT;
  logic [DATA_W-1:0] WB_DATA;
  logic              LAST_WIN;

  modport slave (
    input  A_REQ, A_DR, A_DATA, B_REQ, B_DR, B_DATA,
    output A_GNT, B_GNT, LD_REG, DRMUXOUT, WB_DATA, LAST_WIN
  );

  modport master (
    output A_REQ, A_DR, A_DATA, B_REQ, B_DR, B_DATA,
    input  A_GNT, B_GNT, LD_REG, DRMUXOUT, WB_DATA, LAST_WIN
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port; grant in cycle N, write in N+1.
// Optional conflict counter compiled in with `define WBARB_CONFLICT_CNT_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int DR_W   = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_wb_arbiter_if.slave  bus
`ifdef WBARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]          CONFLICT_CNT
`endif
);

`ifdef WBARB_CONFLICT_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic              w_a_win_p0;
  logic              w_b_win_p0;
  logic              r_vld_p1;
  logic [DR_W-1:0]   r_dr_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_last_win;

  // Stage p0: combinational grant; LAST_WIN=1 means B went last, so A takes a tie.
  always_comb begin
    w_a_win_p0 = 1'b0;
    w_b_win_p0 = 1'b0;
    if (!Reset) begin
      w_a_win_p0 = bus.A_REQ & (~bus.B_REQ | r_last_win);
      w_b_win_p0 = bus.B_REQ & (~bus.A_REQ | ~r_last_win);
    end
  end

  assign bus.A_GNT = w_a_win_p0;
  assign bus.B_GNT = w_b_win_p0;

  // Stage p1: capture the winner; DR/DATA hold when nothing was granted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld_p1   <= 1'b0;
      r_dr_p1    <= '0;
      r_data_p1  <= '0;
      r_last_win <= 1'b1;
    end else begin
      r_vld_p1 <= w_a_win_p0 | w_b_win_p0;
      if (w_a_win_p0) begin
        r_dr_p1    <= bus.A_DR;
        r_data_p1  <= bus.A_DATA;
        r_last_win <= 1'b0;
      end else if (w_b_win_p0) begin
        r_dr_p1    <= bus.B_DR;
        r_data_p1  <= bus.B_DATA;
        r_last_win <= 1'b1;
      end
    end
  end

  assign bus.LD_REG   = r_vld_p1;
  assign bus.DRMUXOUT = r_dr_p1;
  assign bus.WB_DATA  = r_data_p1;
  assign bus.LAST_WIN = r_last_win;

`ifdef WBARB_CONFLICT_CNT_EN
  logic        w_both_p0;
  logic [15:0] r_conflict_cnt;

  assign w_both_p0 = bus.A_REQ & bus.B_REQ;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_conflict_cnt <= 16'h0000;
    end else if (w_both_p0) begin
      r_conflict_cnt <= sat_inc16(r_conflict_cnt);
    end
  end

  assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single grants, round-robin ties,
// same-register ordering, reset during a grant and (optionally) counter saturation.
module tb_regfile_wb_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  int   n_total = 0;
  int   n_pass  = 0;

  regfile_wb_arbiter_if bus ();
`ifdef WBARB_CONFLICT_CNT_EN
  logic [15:0] CONFLICT_CNT;
`endif

  regfile_wb_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef WBARB_CONFLICT_CNT_EN
    ,
    .CONFLICT_CNT (CONFLICT_CNT)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are changed 1 ns after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic [2:0] dr, input logic [15:0] d);
    bus.A_REQ = req; bus.A_DR = dr; bus.A_DATA = d;
  endtask

  task automatic set_b(input logic req, input logic [2:0] dr, input logic [15:0] d);
    bus.B_REQ = req; bus.B_DR = dr; bus.B_DATA = d;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b0, 3'd0, 16'h0);
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    set_a(1'b1, 3'd7, 16'hFFFF);
    set_b(1'b1, 3'd6, 16'hEEEE);
    #2;
    // Grants stay low under reset even with both requesting.
    chk("rst_a_gnt", {15'd0, bus.A_GNT}, 16'd0);
    chk("rst_b_gnt", {15'd0, bus.B_GNT}, 16'd0);
    tick();
    tick();
    chk("rst_ld", {15'd0, bus.LD_REG}, 16'd0);
    chk("rst_dr", {13'd0, bus.DRMUXOUT}, 16'd0);
    chk("rst_data", bus.WB_DATA, 16'h0000);
    chk("rst_last", {15'd0, bus.LAST_WIN}, 16'd1);
`ifdef WBARB_CONFLICT_CNT_EN
    chk("rst_cnt", CONFLICT_CNT, 16'd0);
`endif

    // Single A request for one cycle.
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b0, 3'd0, 16'h0);
    Reset = 1'b0;
    tick();
    set_a(1'b1, 3'd3, 16'h1234);
    #1;
    chk("single_a_gnt", {15'd0, bus.A_GNT}, 16'd1);
    chk("single_b_gnt", {15'd0, bus.B_GNT}, 16'd0);
    tick();
    set_a(1'b0, 3'd0, 16'h0);
    #1;
    chk("single_ld", {15'd0, bus.LD_REG}, 16'd1);
    chk("single_dr", {13'd0, bus.DRMUXOUT}, 16'd3);
    chk("single_data", bus.WB_DATA, 16'h1234);
    chk("single_last", {15'd0, bus.LAST_WIN}, 16'd0);
    chk("single_no_gnt", {15'd0, bus.A_GNT}, 16'd0);
    tick();
    chk("single_ld_off", {15'd0, bus.LD_REG}, 16'd0);
    chk("single_hold", bus.WB_DATA, 16'h1234);

    // Tie after reset: A first, then B.
    do_reset();
    set_a(1'b1, 3'd1, 16'hAAAA);
    set_b(1'b1, 3'd2, 16'h5555);
    #1;
    chk("tie_c0_a", {15'd0, bus.A_GNT}, 16'd1);
    chk("tie_c0_b", {15'd0, bus.B_GNT}, 16'd0);
    tick();
    set_a(1'b0, 3'd0, 16'h0);
    #1;
    chk("tie_c1_b", {15'd0, bus.B_GNT}, 16'd1);
    chk("tie_c1_ld", {15'd0, bus.LD_REG}, 16'd1);
    chk("tie_c1_dr", {13'd0, bus.DRMUXOUT}, 16'd1);
    chk("tie_c1_data", bus.WB_DATA, 16'hAAAA);
    tick();
    set_b(1'b0, 3'd0, 16'h0);
    #1;
    chk("tie_c2_ld", {15'd0, bus.LD_REG}, 16'd1);
    chk("tie_c2_dr", {13'd0, bus.DRMUXOUT}, 16'd2);
    chk("tie_c2_data", bus.WB_DATA, 16'h5555);
    chk("tie_c2_last", {15'd0, bus.LAST_WIN}, 16'd1);
    tick();
    chk("tie_c3_ld", {15'd0, bus.LD_REG}, 16'd0);

    // Sustained tie for 6 cycles with fresh data: A,B,A,B,A,B.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 3'd4, 16'hA000 + 16'(i));
      set_b(1'b1, 3'd6, 16'hB000 + 16'(i));
      #1;
      chk($sformatf("rr_a_gnt%0d", i), {15'd0, bus.A_GNT}, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk($sformatf("rr_b_gnt%0d", i), {15'd0, bus.B_GNT}, (i % 2 == 1) ? 16'd1 : 16'd0);
      tick();
      if (i == 5) begin
        set_a(1'b0, 3'd0, 16'h0);
        set_b(1'b0, 3'd0, 16'h0);
      end
      #1;
      chk($sformatf("rr_ld%0d", i), {15'd0, bus.LD_REG}, 16'd1);
      chk($sformatf("rr_dr%0d", i), {13'd0, bus.DRMUXOUT}, (i % 2 == 0) ? 16'd4 : 16'd6);
      chk($sformatf("rr_data%0d", i), bus.WB_DATA,
          (i % 2 == 0) ? (16'hA000 + 16'(i)) : (16'hB000 + 16'(i)));
    end
`ifdef WBARB_CONFLICT_CNT_EN
    chk("rr_cnt", CONFLICT_CNT, 16'd6);
`endif
    tick();
    chk("rr_ld_off", {15'd0, bus.LD_REG}, 16'd0);

    // Same destination R5: grant order leaves B's data last.
    do_reset();
    set_a(1'b1, 3'd5, 16'h0001);
    set_b(1'b1, 3'd5, 16'h0002);
    tick();
    set_a(1'b0, 3'd0, 16'h0);
    #1;
    chk("r5_first", bus.WB_DATA, 16'h0001);
    tick();
    set_b(1'b0, 3'd0, 16'h0);
    #1;
    chk("r5_dr", {13'd0, bus.DRMUXOUT}, 16'd5);
    chk("r5_final", bus.WB_DATA, 16'h0002);
    chk("r5_ld", {15'd0, bus.LD_REG}, 16'd1);

    // Reset arriving in the cycle of a B grant cancels the write.
    do_reset();
    set_a(1'b1, 3'd7, 16'hBEEF);
    tick();
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b1, 3'd6, 16'hCAFE);
    #1;
    chk("rstg_b_gnt", {15'd0, bus.B_GNT}, 16'd1);
    chk("rstg_pre_data", bus.WB_DATA, 16'hBEEF);
    Reset = 1'b1;
    #1;
    chk("rstg_b_gnt_off", {15'd0, bus.B_GNT}, 16'd0);
    tick();
    chk("rstg_ld", {15'd0, bus.LD_REG}, 16'd0);
    chk("rstg_dr", {13'd0, bus.DRMUXOUT}, 16'd0);
    chk("rstg_data", bus.WB_DATA, 16'h0000);
    chk("rstg_last", {15'd0, bus.LAST_WIN}, 16'd1);
    set_b(1'b0, 3'd0, 16'h0);
    Reset = 1'b0;
    tick();
    chk("rstg_no_pulse", {15'd0, bus.LD_REG}, 16'd0);

`ifdef WBARB_CONFLICT_CNT_EN
    // Drive the counter to saturation with real conflicts.
    do_reset();
    set_a(1'b1, 3'd1, 16'h1111);
    set_b(1'b1, 3'd2, 16'h2222);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", CONFLICT_CNT, 16'hFFFE);
    tick();
    chk("sat_ffff", CONFLICT_CNT, 16'hFFFF);
    tick();
    chk("sat_hold", CONFLICT_CNT, 16'hFFFF);
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b0, 3'd0, 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL use one clock and synchronous, active-high reset, with ports named Clk and Reset.
REQ-002 SHALL have port Clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port A_REQ, input, 1 bit: requester A (ALU writeback) write request.
REQ-005 SHALL have port A_DR, input, 3 bits: requester A destination register.
REQ-006 SHALL have port A_DATA, input, 16 bits: requester A write data.
REQ-007 SHALL have port A_GNT, output, 1 bit: one-cycle grant to requester A.
REQ-008 SHALL have ports B_REQ, B_DR, B_DATA and B_GNT with the same directions, widths and meanings as the A ports, for requester B (memory load writeback).
REQ-009 SHALL have port LD_REG, output, 1 bit: register file write enable.
REQ-010 SHALL have port DRMUXOUT, output, 3 bits: register file destination select.
REQ-011 SHALL have port WB_DATA, output, 16 bits: register file write data (drives the register file BUS input).
REQ-012 SHALL have port LAST_WIN, output, 1 bit: last granted requester (0 = A, 1 = B).
REQ-013 SHALL have port CONFLICT_CNT, output, 16 bits, present only when WBARB_CONFLICT_CNT_EN is defined (see REQ-030).

Function
REQ-014 SHALL arbitrate the single register file write port between A and B, granting at most one requester per cycle.
REQ-015 SHALL evaluate grants combinationally in cycle N: assert X_GNT if X_REQ=1 and X wins.
REQ-016 SHALL, at the cycle N+1 edge, register the winner's DR and DATA into DRMUXOUT/WB_DATA and set LD_REG=1 for exactly cycle N+1.
REQ-017 SHALL give a fixed write latency of one cycle from grant to LD_REG.
REQ-018 SHALL, in any cycle with no grant, drive LD_REG=0 next cycle and hold DRMUXOUT/WB_DATA at their previous values.
REQ-019 SHALL resolve a single requester: the asserted requester wins regardless of priority.
REQ-020 SHALL resolve simultaneous A_REQ and B_REQ round-robin: the winner is the requester not equal to LAST_WIN; LAST_WIN updates to the winner on every grant.
REQ-021 SHALL require a requester to hold REQ/DR/DATA stable until its GNT; the losing request is granted in the next cycle if still held (maximum wait one cycle, no starvation).
REQ-022 SHALL support back-to-back grants: sustained requests produce LD_REG=1 every cycle, alternating A,B,A,B while both are asserted.
REQ-023 SHALL, for simultaneous requests to the same DR, perform the writes in grant order, so the later grantee's data is the final register value.
REQ-024 SHALL, when REQ is sampled in the same cycle as the previous GNT, treat it as a new request.
REQ-025 SHALL keep DR and DATA at full width, with no arithmetic on data.

Reset
REQ-026 SHALL, while Reset=1, drive A_GNT=0 and B_GNT=0 combinationally, regardless of REQ.
REQ-027 SHALL, at the reset edge, clear LD_REG=0, DRMUXOUT=3'b000, WB_DATA=16'h0000 and LAST_WIN=1 (so A wins the first tie) and CONFLICT_CNT=0.
REQ-028 SHALL, on reset mid-operation, cancel any write captured on the same edge; no LD_REG pulse follows reset.

Configuration
REQ-029 SHALL use the macro WBARB_CONFLICT_CNT_EN to compile the conflict counter in or out.
REQ-030 SHALL, with WBARB_CONFLICT_CNT_EN defined, increment CONFLICT_CNT on every non-reset cycle where A_REQ=1 and B_REQ=1, saturating at 16'hFFFF.
REQ-031 SHALL, without WBARB_CONFLICT_CNT_EN defined, have no CONFLICT_CNT port and no counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: A_REQ=1, A_DR=3, A_DATA=16'h1234 for one cycle -> A_GNT=1 that cycle; next cycle LD_REG=1, DRMUXOUT=3, WB_DATA=16'h1234; then LD_REG=0.
REQ-033 SHALL cover: after reset, A(R1,16'hAAAA) and B(R2,16'h5555) both held -> cycle 0 A_GNT; cycle 1 B_GNT with LD_REG writing R1=AAAA; cycle 2 LD_REG writing R2=5555.
REQ-034 SHALL cover: both held continuously for 6 cycles with fresh data -> grants alternate A,B,A,B,A,B; LD_REG=1 for 6 consecutive cycles; CONFLICT_CNT=6 when the macro is defined.
REQ-035 SHALL cover: A and B both target R5 (A=16'h0001, B=16'h0002) after reset -> final WB_DATA written to R5 is 16'h0002.
REQ-036 SHALL cover: Reset asserted in the cycle of a B grant -> B_GNT=0, no LD_REG pulse the next cycle, all outputs at reset values.
REQ-037 SHALL cover: CONFLICT_CNT preloaded to 16'hFFFF by forced conflicts, then a further conflict -> remains 16'hFFFF.
